// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush sequencer with load-use detection, memory-wait freeze, operand forwarding and stall counter
// Ports: clk; reset (async, active-low); dec_rs/dec_rt + dec_uses_rs/dec_uses_rt (decode sources);
//   dec_redirect (branch/jump resolved); ex_dest/ex_reg_write/ex_mem_read (execute stage);
//   mem_dest/mem_reg_write (memory stage); dmem_req/dmem_ready (data memory handshake);
//   pc_en, fd_en, fd_flush, de_bubble, pipe_hold (pipeline controls);
//   fwd_a_sel/fwd_b_sel (00 regfile, 01 execute, 10 memory); stall_count (saturating); state (debug).
module hazard_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       dec_rs,
    input  logic [4:0]       dec_rt,
    input  logic             dec_uses_rs,
    input  logic             dec_uses_rt,
    input  logic             dec_redirect,
    input  logic [4:0]       ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_dest,
    input  logic             mem_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd2, FLUSH = 2'd3} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     st, st_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       mem_stall, load_use, ex_fwd, mem_fwd;

    assign mem_stall = dmem_req && !dmem_ready;
    assign load_use  = ex_mem_read && ex_reg_write && ex_dest != 5'd0 &&
                       ((dec_uses_rs && dec_rs == ex_dest) || (dec_uses_rt && dec_rt == ex_dest));
    // a load's data is not available from execute, so only non-load results forward from there
    assign ex_fwd    = ex_reg_write && !ex_mem_read && ex_dest != 5'd0;
    assign mem_fwd   = mem_reg_write && mem_dest != 5'd0;
    assign state     = st;

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        pipe_hold = 1'b0;
        fwd_a_sel = (ex_fwd && ex_dest == dec_rs) ? 2'b01 : (mem_fwd && mem_dest == dec_rs) ? 2'b10 : 2'b00;
        fwd_b_sel = (ex_fwd && ex_dest == dec_rt) ? 2'b01 : (mem_fwd && mem_dest == dec_rt) ? 2'b10 : 2'b00;
        case (st)
            RUN: begin
                if (mem_stall) begin
                    pipe_hold = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    st_nxt    = MEM_WAIT;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    de_bubble = 1'b1;
                end else if (dec_redirect) begin
                    fd_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nxt = FLUSH_LOAD;
                        st_nxt  = FLUSH;
                    end
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    pipe_hold = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                end else begin
                    st_nxt = RUN;
                end
            end
            FLUSH: begin
                fd_flush = 1'b1;
                // a memory stall freezes the flush countdown so only non-held cycles count
                if (mem_stall) begin
                    pipe_hold = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) st_nxt = RUN;
                end
            end
            default: st_nxt = RUN;
        endcase
        if (!reset) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            fd_flush  = 1'b0;
            de_bubble = 1'b1;
            pipe_hold = 1'b0;
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= RUN;
            cnt         <= 4'd0;
            stall_count <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            if (!pc_en && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scenario tasks against a scoreboard of expected per-cycle outputs
module tb_hazard_controller;
    logic       clk, reset;
    logic [4:0] dec_rs, dec_rt, ex_dest, mem_dest;
    logic       dec_uses_rs, dec_uses_rt, dec_redirect, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, dmem_req, dmem_ready;
    logic       pc_en, fd_en, fd_flush, de_bubble, pipe_hold;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;
    logic [3:0] stall_count;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t       q[$];
    logic [3:0] exp_sc = 4'd0;
    int         cmp = 0;
    int         mism = 0;

    hazard_controller #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_redirect(dec_redirect), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_bubble(de_bubble),
        .pipe_hold(pipe_hold), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [14:0] obs();
        return {pc_en, fd_en, fd_flush, de_bubble, pipe_hold, fwd_a_sel, fwd_b_sel, state, stall_count};
    endfunction

    // pushes this cycle's expected outputs; the stall counter model is advanced for the coming edge
    function automatic void expect_cyc(string tag, logic pc, logic fd, logic fl, logic bub, logic hold,
                                       logic [1:0] fa, logic [1:0] fb, logic [1:0] st);
        if (!reset) exp_sc = 4'd0;
        q.push_back('{tag, {pc, fd, fl, bub, hold, fa, fb, st, exp_sc}});
        if (!pc && reset && exp_sc != 4'hf) exp_sc = exp_sc + 4'd1;
    endfunction

    task automatic clr();
        dec_rs = 0; dec_rt = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_redirect = 0;
        ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0; mem_dest = 0; mem_reg_write = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        clr();
        reset = 0; dec_rs = 3; dec_uses_rs = 1; ex_dest = 3; ex_reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1;
            if (i < 2) expect_cyc("reset_hold", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0);
            else expect_cyc("reset_release", 1, 1, 0, 0, 0, 2'b01, 2'b00, 2'd0);
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s cyc%0d: got %b expected %b", e.tag, i, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            clr();
            case (i)
                0: begin ex_dest = 5; ex_mem_read = 1; ex_reg_write = 1; dec_rs = 5; dec_uses_rs = 1;
                          expect_cyc("load_use_stall", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0); end
                1: begin dec_rs = 5; dec_uses_rs = 1; mem_dest = 5; mem_reg_write = 1;
                          expect_cyc("load_use_fwd_mem", 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'd0); end
                2: begin ex_dest = 9; ex_mem_read = 1; ex_reg_write = 1; dec_rs = 9;
                          expect_cyc("load_use_unused_rs", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0); end
                3: begin ex_dest = 9; ex_mem_read = 1; ex_reg_write = 1; dec_rt = 9; dec_uses_rt = 1;
                          expect_cyc("load_use_rt", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0); end
                4: begin ex_mem_read = 1; ex_reg_write = 1; dec_uses_rs = 1; dec_uses_rt = 1;
                          expect_cyc("load_use_r0", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0); end
                default: begin ex_dest = 6; ex_mem_read = 1; dec_rs = 6; dec_uses_rs = 1;
                          expect_cyc("load_no_write", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0); end
            endcase
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s: got %b expected %b", e.tag, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            clr();
            case (i)
                0: begin ex_dest = 7; ex_reg_write = 1; mem_dest = 7; mem_reg_write = 1; dec_rt = 7;
                          expect_cyc("fwd_ex_beats_mem", 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'd0); end
                1: begin ex_reg_write = 1; mem_reg_write = 1;
                          expect_cyc("fwd_dest_zero", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0); end
                2: begin ex_dest = 4; ex_reg_write = 1; mem_dest = 7; mem_reg_write = 1; dec_rs = 7; dec_rt = 4;
                          expect_cyc("fwd_split", 1, 1, 0, 0, 0, 2'b10, 2'b01, 2'd0); end
                3: begin ex_dest = 7; mem_dest = 7; mem_reg_write = 1; dec_rs = 7; dec_rt = 7;
                          expect_cyc("fwd_ex_nowrite", 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'd0); end
                default: begin ex_dest = 7; ex_reg_write = 1; ex_mem_read = 1; mem_dest = 7; mem_reg_write = 1;
                          dec_rs = 7; dec_rt = 7;
                          expect_cyc("fwd_ex_load", 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'd0); end
            endcase
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s: got %b expected %b", e.tag, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            clr();
            if (i < 4) dmem_req = 1;
            if (i >= 1 && i <= 3) begin
                ex_dest = 5; ex_mem_read = 1; ex_reg_write = 1; dec_rs = 5; dec_uses_rs = 1; dec_redirect = 1;
            end
            if (i == 3) dmem_ready = 1;
            case (i)
                0: expect_cyc("mem_enter", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
                1, 2: expect_cyc("mem_wait_hold", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'd2);
                3: expect_cyc("mem_ready", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd2);
                default: expect_cyc("mem_back_run", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
            endcase
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s cyc%0d: got %b expected %b", e.tag, i, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            clr();
            dec_redirect = (i == 0 || i == 1 || i == 4);
            if (i == 5 || i == 6) dmem_req = 1;
            if (i == 7) begin dmem_req = 1; dmem_ready = 1; end
            case (i)
                0, 4: expect_cyc("redir_start", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0);
                1, 2, 7, 8: expect_cyc("redir_flush", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd3);
                5, 6: expect_cyc("redir_flush_held", 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'd3);
                default: expect_cyc("redir_done", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
            endcase
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s cyc%0d: got %b expected %b", e.tag, i, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            clr();
            if (i == 0) begin
                ex_dest = 5; ex_mem_read = 1; ex_reg_write = 1; dec_rs = 5; dec_uses_rs = 1; dec_redirect = 1;
                expect_cyc("simul_bubble_only", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0);
            end else expect_cyc("simul_no_flush", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s: got %b expected %b", e.tag, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            clr();
            dec_redirect = (i == 0);
            reset = (i != 1);
            case (i)
                0: expect_cyc("abort_redirect", 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0);
                1: expect_cyc("abort_in_flush", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'd0);
                default: expect_cyc("abort_run", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
            endcase
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s cyc%0d: got %b expected %b", e.tag, i, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int i = 0; i < 22; i++) begin
            clr();
            dmem_req = (i <= 20);
            dmem_ready = (i == 20);
            if (i == 0) expect_cyc("sat_enter", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'd0);
            else if (i < 20) expect_cyc("sat_hold", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'd2);
            else if (i == 20) expect_cyc("sat_ready", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd2);
            else expect_cyc("sat_final", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0);
            @(negedge clk); e = q.pop_front(); cmp++;
            if (obs() !== e.v) begin mism++; $display("FAIL %s cyc%0d: got %b expected %b", e.tag, i, obs(), e.v); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 0;
        clr();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_redirect();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
